// File: rtl/regfile_dbg_pkg.sv
// Shared types and register-code helpers for the register-file debug sequencer.
// Register codes match register_file: R0-R7 = 0-7, ACC = 8, DBAR/DOFF/IBAR/IOFF = 9-12, STATUS = 13.
package regfile_dbg_pkg;

  localparam int RFD_ADDR_W = 4;

  localparam logic [RFD_ADDR_W-1:0] REG_ACC    = 4'd8;
  localparam logic [RFD_ADDR_W-1:0] REG_STATUS = 4'd13;

  typedef enum logic [2:0] {
    RFD_IDLE,
    RFD_RD,
    RFD_ACC_LD,
    RFD_W_LD,
    RFD_W_PUT,
    RFD_W_RST,
    RFD_DONE
  } rfd_state_t;

  // STATUS is the highest defined code; everything below it is debug-writable.
  function automatic logic rfd_is_writable(input logic [RFD_ADDR_W-1:0] addr);
    return addr < REG_STATUS;
  endfunction

endpackage

// File: rtl/regfile_debug_sequencer.sv
// Muxes register-file controls between the core and a debug port, replaying debug accesses
// as register-file operation sequences.
// state  | meaning
// IDLE   | core owns rf_*; debug accepted when core idle or starved
// RD     | drive read of latched address, capture read bus
// ACC_LD | load ACC with debug write data
// W_LD   | load ACC with write data, save old ACC in shadow
// W_PUT  | store ACC into latched register
// W_RST  | restore ACC from shadow
// DONE   | ack (with err for illegal access)
module regfile_debug_sequencer
  import regfile_dbg_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int STARVE_LIMIT   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      core_active,
  input  logic [REG_ADDR_WIDTH-1:0] core_reg_addr,
  input  logic                      core_read_oe,
  input  logic                      core_acc_we,
  input  logic                      core_get_to_acc,
  input  logic                      core_put_acc,
  input  logic                      core_status_we,
  input  logic [DATA_W-1:0]         core_acc_in,
  output logic                      core_stall,
  input  logic                      dbg_req,
  input  logic                      dbg_we,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_W-1:0]         dbg_wdata,
  output logic                      dbg_ack,
  output logic                      dbg_err,
  output logic [DATA_W-1:0]         dbg_rdata,
  output logic [REG_ADDR_WIDTH-1:0] rf_reg_addr,
  output logic                      rf_read_oe,
  output logic                      rf_acc_we,
  output logic                      rf_get_to_acc,
  output logic                      rf_put_acc,
  output logic                      rf_status_we,
  output logic [DATA_W-1:0]         rf_acc_in,
  input  logic [DATA_W-1:0]         rf_acc_out,
  input  logic [DATA_W-1:0]         rf_read_data
);

  localparam int                CNT_W      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  rfd_state_t                state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic [DATA_W-1:0]         shadow_q, shadow_d;
  logic [DATA_W-1:0]         rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic [CNT_W-1:0]          starve_q, starve_d;

  logic                  accept, forced, dbg_bad, addr_in_range;
  logic [RFD_ADDR_W-1:0] dbg_code;

  // Addresses wider than the code space are only legal when the upper bits are zero.
  assign dbg_code      = RFD_ADDR_W'(dbg_addr);
  assign addr_in_range = (REG_ADDR_WIDTH'(dbg_code) == dbg_addr);
  assign dbg_bad       = !(addr_in_range && rfd_is_writable(dbg_code));
  assign dbg_rdata     = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RFD_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    shadow_d      = shadow_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    starve_d      = starve_q;
    accept        = 1'b0;
    forced        = 1'b0;
    rf_reg_addr   = '0;
    rf_read_oe    = 1'b0;
    rf_acc_we     = 1'b0;
    rf_get_to_acc = 1'b0;
    rf_put_acc    = 1'b0;
    rf_status_we  = 1'b0;
    rf_acc_in     = '0;
    core_stall    = 1'b1;
    dbg_ack       = 1'b0;
    dbg_err       = 1'b0;

    unique case (state_q)
      RFD_IDLE: begin
        accept      = dbg_req && (!core_active || starve_q == STARVE_MAX);
        forced      = accept && core_active;
        core_stall  = forced;
        rf_reg_addr = core_reg_addr;
        rf_acc_in   = core_acc_in;
        if (!forced) begin
          rf_read_oe    = core_read_oe;
          rf_acc_we     = core_acc_we;
          rf_get_to_acc = core_get_to_acc;
          rf_put_acc    = core_put_acc;
          rf_status_we  = core_status_we;
        end
        if (accept) begin
          starve_d = '0;
          addr_d   = dbg_addr;
          wdata_d  = dbg_wdata;
          err_d    = dbg_bad;
          if (dbg_bad)                  state_d = RFD_DONE;
          else if (!dbg_we)             state_d = RFD_RD;
          else if (dbg_code == REG_ACC) state_d = RFD_ACC_LD;
          else                          state_d = RFD_W_LD;
        end else if (!dbg_req) begin
          starve_d = '0;
        end else if (core_active && starve_q != STARVE_MAX) begin
          starve_d = starve_q + CNT_W'(1);
        end
      end
      RFD_RD: begin
        rf_reg_addr = addr_q;
        rf_read_oe  = 1'b1;
        rdata_d     = rf_read_data;
        state_d     = RFD_DONE;
      end
      RFD_ACC_LD: begin
        rf_acc_we = 1'b1;
        rf_acc_in = wdata_q;
        state_d   = RFD_DONE;
      end
      RFD_W_LD: begin
        rf_acc_we = 1'b1;
        rf_acc_in = wdata_q;
        shadow_d  = rf_acc_out;
        state_d   = RFD_W_PUT;
      end
      RFD_W_PUT: begin
        rf_reg_addr = addr_q;
        rf_put_acc  = 1'b1;
        state_d     = RFD_W_RST;
      end
      RFD_W_RST: begin
        rf_acc_we = 1'b1;
        rf_acc_in = shadow_q;
        state_d   = RFD_DONE;
      end
      RFD_DONE: begin
        dbg_ack = 1'b1;
        dbg_err = err_q;
        state_d = RFD_IDLE;
      end
      default: state_d = RFD_IDLE;
    endcase
  end

endmodule
